// File: rtl/bias_add_stream_pkg.sv
// -----------------------------------------------------------------------------
// bias_add_stream_pkg
//   Shared definitions for the bias-add stream consumer:
//     - state encoding for the LOAD / RUN frame phases
//     - counter width helper (clog2 with a floor of one bit)
//     - signed saturation limits for an arbitrary result width
//   No ports; imported by the other files of this block.
// -----------------------------------------------------------------------------
package bias_add_stream_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_LOAD = 1'b0;  // popping bias coefficients into the bank
    localparam state_t ST_RUN  = 1'b1;  // streaming accumulator words through the adder

    // Counter width able to hold 0..n-1; a single-entry count still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Largest value representable in a signed w-bit word, as a 64-bit signed value.
    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a signed w-bit word, as a 64-bit signed value.
    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/bias_add_stream_out_reg_stage.sv
// -----------------------------------------------------------------------------
// bias_add_stream_out_reg_stage
//   Single-entry output register in front of an ap_fifo-style write port.
//   The word is held unchanged while the downstream FIFO is full, and a new
//   word may be loaded in the same cycle the current one drains.
//
//   Ports:
//     clk_i     in   clock, rising edge
//     rst_n_i   in   asynchronous active-low reset
//     load_i    in   capture data_i this cycle (only when ready_o=1)
//     data_i    in   word to capture
//     full_n_i  in   downstream FIFO not full
//     ready_o   out  register is empty or draining this cycle
//     valid_o   out  register holds a word (drives the FIFO write strobe)
//     data_o    out  held word (drives the FIFO data)
// -----------------------------------------------------------------------------
module bias_add_stream_out_reg_stage
    import bias_add_stream_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             full_n_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    assign ready_o = !valid_q || full_n_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && full_n_i) begin
            // Drained with nothing to refill; data is left as-is.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/bias_add_stream.sv
// -----------------------------------------------------------------------------
// bias_add_stream
//   Consumer end of the bias coefficient stream. Each frame first pops KERN_S
//   bias words into a local bank (LOAD), then streams PIXELS*KERN_S
//   channel-interleaved accumulator words, adds the channel's bias with signed
//   saturation and pushes the results downstream (RUN).
//
//   Ports:
//     ap_clk           in   clock, rising edge
//     ap_rst_n         in   asynchronous active-low reset
//     bias_V_dout      in   bias word at FIFO head
//     bias_V_empty_n   in   bias FIFO non-empty
//     bias_V_read      out  pop bias FIFO
//     acc_V_dout       in   accumulator word at FIFO head
//     acc_V_empty_n    in   accumulator FIFO non-empty
//     acc_V_read       out  pop accumulator FIFO
//     output_V_din     out  biased, saturated result
//     output_V_full_n  in   downstream FIFO not full
//     output_V_write   out  push result
//     frame_done       out  one-cycle pulse after the last accumulator pop
// -----------------------------------------------------------------------------
module bias_add_stream
    import bias_add_stream_pkg::*;
#(
    parameter int KERN_S      = 16,
    parameter int PIXELS      = 64,
    parameter int COEFF_WIDTH = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 32
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [COEFF_WIDTH-1:0] bias_V_dout,
    input  logic                   bias_V_empty_n,
    output logic                   bias_V_read,
    input  logic [ACC_WIDTH-1:0]   acc_V_dout,
    input  logic                   acc_V_empty_n,
    output logic                   acc_V_read,
    output logic [OUT_WIDTH-1:0]   output_V_din,
    input  logic                   output_V_full_n,
    output logic                   output_V_write,
    output logic                   frame_done
);

    localparam int KW = cnt_width(KERN_S);
    localparam int PW = cnt_width(PIXELS);
    localparam int SW = ACC_WIDTH + 1;  // sum width: one guard bit above the accumulator

    localparam logic [KW-1:0] K_LAST = KW'(KERN_S - 1);
    localparam logic [PW-1:0] P_LAST = PW'(PIXELS - 1);

    localparam logic signed [63:0]   MAX64   = sat_max(OUT_WIDTH);
    localparam logic signed [63:0]   MIN64   = sat_min(OUT_WIDTH);
    localparam logic signed [SW-1:0] OUT_MAX = MAX64[SW-1:0];
    localparam logic signed [SW-1:0] OUT_MIN = MIN64[SW-1:0];

    state_t          state_q, state_d;
    logic [KW-1:0]   bidx_q,  bidx_d;
    logic [KW-1:0]   ch_q,    ch_d;
    logic [PW-1:0]   pix_q,   pix_d;
    logic            frame_done_q, frame_done_d;

    logic [COEFF_WIDTH-1:0] bank_q [KERN_S];

    logic                   stage_ready;
    logic [COEFF_WIDTH-1:0] bias_word;
    logic signed [SW-1:0]   acc_ext;
    logic signed [SW-1:0]   bias_ext;
    logic signed [SW-1:0]   sum;
    logic [OUT_WIDTH-1:0]   sat_result;

    // Each FIFO is only popped in its own phase; the other stream's words wait.
    assign bias_V_read = (state_q == ST_LOAD) && bias_V_empty_n;
    assign acc_V_read  = (state_q == ST_RUN) && acc_V_empty_n && stage_ready;
    assign frame_done  = frame_done_q;

    assign bias_word = bank_q[ch_q];
    assign acc_ext   = {acc_V_dout[ACC_WIDTH-1], acc_V_dout};
    assign bias_ext  = {{(SW - COEFF_WIDTH){bias_word[COEFF_WIDTH-1]}}, bias_word};
    assign sum       = acc_ext + bias_ext;

    always_comb begin
        sat_result = sum[OUT_WIDTH-1:0];
        if (sum > OUT_MAX) begin
            sat_result = OUT_MAX[OUT_WIDTH-1:0];
        end else if (sum < OUT_MIN) begin
            sat_result = OUT_MIN[OUT_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        bidx_d       = bidx_q;
        ch_d         = ch_q;
        pix_d        = pix_q;
        frame_done_d = 1'b0;

        if (bias_V_read) begin
            if (bidx_q == K_LAST) begin
                bidx_d  = '0;
                state_d = ST_RUN;
            end else begin
                bidx_d = bidx_q + 1'b1;
            end
        end

        if (acc_V_read) begin
            if (ch_q == K_LAST) begin
                ch_d = '0;
                if (pix_q == P_LAST) begin
                    pix_d        = '0;
                    state_d      = ST_LOAD;
                    frame_done_d = 1'b1;
                end else begin
                    pix_d = pix_q + 1'b1;
                end
            end else begin
                ch_d = ch_q + 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= ST_LOAD;
            bidx_q       <= '0;
            ch_q         <= '0;
            pix_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bidx_q       <= bidx_d;
            ch_q         <= ch_d;
            pix_q        <= pix_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Bank contents need no reset: every frame rewrites all entries before RUN.
    always_ff @(posedge ap_clk) begin
        if (bias_V_read) begin
            bank_q[bidx_q] <= bias_V_dout;
        end
    end

    bias_add_stream_out_reg_stage #(
        .WIDTH (OUT_WIDTH)
    ) u_out_reg (
        .clk_i    (ap_clk),
        .rst_n_i  (ap_rst_n),
        .load_i   (acc_V_read),
        .data_i   (sat_result),
        .full_n_i (output_V_full_n),
        .ready_o  (stage_ready),
        .valid_o  (output_V_write),
        .data_o   (output_V_din)
    );

endmodule

// File: tb/tb_bias_add_stream.sv
module tb_bias_add_stream;

    localparam int K  = 4;
    localparam int P  = 2;
    localparam int N  = K * P;
    localparam int CW = 16;
    localparam int AW = 32;
    localparam int OW = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic          ap_clk;
    logic          ap_rst_n;
    logic [CW-1:0] bias_V_dout;
    logic          bias_V_empty_n;
    logic          bias_V_read;
    logic [AW-1:0] acc_V_dout;
    logic          acc_V_empty_n;
    logic          acc_V_read;
    logic [OW-1:0] output_V_din;
    logic          output_V_full_n;
    logic          output_V_write;
    logic          frame_done;

    bias_add_stream #(
        .KERN_S(K), .PIXELS(P), .COEFF_WIDTH(CW), .ACC_WIDTH(AW), .OUT_WIDTH(OW)
    ) dut (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .bias_V_dout     (bias_V_dout),
        .bias_V_empty_n  (bias_V_empty_n),
        .bias_V_read     (bias_V_read),
        .acc_V_dout      (acc_V_dout),
        .acc_V_empty_n   (acc_V_empty_n),
        .acc_V_read      (acc_V_read),
        .output_V_din    (output_V_din),
        .output_V_full_n (output_V_full_n),
        .output_V_write  (output_V_write),
        .frame_done      (frame_done)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    typedef struct {
        logic [AW-1:0] acc;
        logic [CW-1:0] bias;
        logic [OW-1:0] exp;
    } vec_t;

    vec_t tab [2*N];

    // FIFO contents and scoreboard
    logic [CW-1:0] bias_q [$];
    logic [AW-1:0] acc_q  [$];
    logic [OW-1:0] exp_q  [$];
    logic [CW-1:0] fb [K];
    logic [AW-1:0] fa [N];
    logic [OW-1:0] fe [N];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    // Frame-level view of the stream: how far through LOAD and RUN we are.
    int m_bias = 0, m_acc = 0, acc_pops = 0, outs = 0, exp_pushed = 0, exp_dropped = 0;
    bit fd_exp = 1'b0;
    bit bias_rand = 1'b0, acc_rand = 1'b0, full_rand = 1'b0;
    int bias_hold = 0, stall_after = -1, stall_left = 0;
    bit prev_stall = 1'b0;
    logic [OW-1:0] prev_din = '0;
    int first_acc = -1, last_acc = -1, last_out = -1;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic logic [OW-1:0] ref_sat(input logic [AW-1:0] a, input logic [CW-1:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        if (s > SMAX) return 32'h7FFF_FFFF;
        if (s < SMIN) return 32'h8000_0000;
        return s[OW-1:0];
    endfunction

    task automatic set_vec(input int idx, input logic [AW-1:0] a, input logic [CW-1:0] b, input logic [OW-1:0] e);
        tab[idx].acc = a; tab[idx].bias = b; tab[idx].exp = e;
    endtask

    task automatic load_tab(input int base);
        for (int i = 0; i < N; i++) begin
            fa[i] = tab[base+i].acc;
            fe[i] = tab[base+i].exp;
            if (i < K) fb[i] = tab[base+i].bias;
        end
    endtask

    task automatic rand_frame();
        for (int k = 0; k < K; k++)
            fb[k] = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000) : 16'($urandom);
        for (int i = 0; i < N; i++) begin
            fa[i] = ($urandom_range(0, 3) == 0) ?
                    {(($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000), 16'($urandom)} : $urandom;
            fe[i] = ref_sat(fa[i], fb[i % K]);
        end
    endtask

    task automatic queue_frame();
        for (int k = 0; k < K; k++) bias_q.push_back(fb[k]);
        for (int i = 0; i < N; i++) begin
            acc_q.push_back(fa[i]);
            exp_q.push_back(fe[i]);
            exp_pushed++;
        end
    endtask

    // One clock cycle: drive FIFO heads after the falling edge, check strobes,
    // account transfers at the rising edge, then check frame_done.
    task automatic tick();
        bit pend, exp_brd, exp_ard;
        logic [OW-1:0] e;
        if (stall_after >= 0 && outs >= stall_after) begin
            stall_left  = 5;
            stall_after = -1;
        end
        bias_V_empty_n  = (bias_q.size() > 0) && (bias_hold == 0) && (!bias_rand || $urandom_range(0, 3) != 0);
        bias_V_dout     = (bias_q.size() > 0) ? bias_q[0] : '0;
        acc_V_empty_n   = (acc_q.size() > 0) && (!acc_rand || $urandom_range(0, 3) != 0);
        acc_V_dout      = (acc_q.size() > 0) ? acc_q[0] : '0;
        output_V_full_n = (stall_left > 0) ? 1'b0 : (!full_rand || $urandom_range(0, 3) != 0);
        if (stall_left > 0) stall_left--;
        if (bias_hold > 0) bias_hold--;
        #1;
        pend    = (acc_pops > outs);
        exp_brd = (m_bias < K) && bias_V_empty_n;
        exp_ard = (m_bias == K) && acc_V_empty_n && (!pend || output_V_full_n);
        chk(bias_V_read == exp_brd, "bias_read", 64'(bias_V_read), 64'(exp_brd));
        chk(acc_V_read == exp_ard, "acc_read", 64'(acc_V_read), 64'(exp_ard));
        chk(output_V_write == pend, "out_write", 64'(output_V_write), 64'(pend));
        if (prev_stall) chk(output_V_din == prev_din, "hold_din", 64'(output_V_din), 64'(prev_din));
        prev_stall = output_V_write && !output_V_full_n;
        prev_din   = output_V_din;
        fd_exp     = 1'b0;
        if (output_V_write && output_V_full_n) begin
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_out", 64'(output_V_din), 64'd0);
            end else begin
                e = exp_q.pop_front();
                $display("xfer %0d: din=0x%08h expected=0x%08h", outs, output_V_din, e);
                chk(output_V_din == e, "out_data", 64'(output_V_din), 64'(e));
            end
            outs++;
            last_out = cyc;
        end
        if (bias_V_read) begin
            void'(bias_q.pop_front());
            m_bias++;
        end
        if (acc_V_read) begin
            void'(acc_q.pop_front());
            acc_pops++;
            m_acc++;
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
            if (m_acc == N) begin
                m_acc  = 0;
                m_bias = 0;
                fd_exp = 1'b1;
            end
        end
        @(posedge ap_clk);
        #1;
        chk(frame_done == fd_exp, "frame_done", 64'(frame_done), 64'(fd_exp));
        @(negedge ap_clk);
        cyc++;
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while ((bias_q.size() > 0 || acc_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        chk(n < budget, name, 64'(n), 64'(budget));
    endtask

    initial begin
        int start, guard;
        ap_rst_n        = 1'b0;
        bias_V_dout     = '0;
        bias_V_empty_n  = 1'b0;
        acc_V_dout      = '0;
        acc_V_empty_n   = 1'b0;
        output_V_full_n = 1'b1;

        // Basic frame: biases {1,-2,3,-4}, acc 0..7
        set_vec(0, 32'd0,  16'd1,     32'd1);
        set_vec(1, 32'd1, -16'sd2,   -32'sd1);
        set_vec(2, 32'd2,  16'd3,     32'd5);
        set_vec(3, 32'd3, -16'sd4,   -32'sd1);
        set_vec(4, 32'd4,  16'd1,     32'd5);
        set_vec(5, 32'd5, -16'sd2,    32'd3);
        set_vec(6, 32'd6,  16'd3,     32'd9);
        set_vec(7, 32'd7, -16'sd4,    32'd3);
        // Saturation frame: biases {100,-100,32767,-32768}
        set_vec(8,  32'h7FFF_FFF0,  16'd100,    32'h7FFF_FFFF);
        set_vec(9,  32'h8000_0010, -16'sd100,   32'h8000_0000);
        set_vec(10, 32'h7FFF_0000,  16'h7FFF,   32'h7FFF_7FFF);
        set_vec(11, 32'h8000_0000,  16'h8000,   32'h8000_0000);
        set_vec(12, 32'h7FFF_FF9B,  16'd100,    32'h7FFF_FFFF);
        set_vec(13, 32'h8000_0064, -16'sd100,   32'h8000_0000);
        set_vec(14, 32'hFFFF_FFFF,  16'h7FFF,   32'h0000_7FFE);
        set_vec(15, 32'h0000_0005,  16'h8000,   32'hFFFF_8005);

        repeat (3) @(negedge ap_clk);
        #1;
        chk(output_V_write == 1'b0, "reset_write", 64'(output_V_write), 64'd0);
        chk(output_V_din == '0, "reset_din", 64'(output_V_din), 64'd0);
        chk(frame_done == 1'b0, "reset_frame_done", 64'(frame_done), 64'd0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        // Basic frame; accumulator words sit ready while biases are held off
        load_tab(0);
        bias_hold = 3;
        queue_frame();
        drain(200, "basic_timeout");

        // Throughput: everything always ready
        load_tab(0);
        start = cyc;
        first_acc = -1;
        queue_frame();
        drain(200, "thru_timeout");
        chk(first_acc - start == K, "thru_first_acc", 64'(first_acc - start), 64'(K));
        chk(last_acc - first_acc + 1 == N, "thru_run_len", 64'(last_acc - first_acc + 1), 64'(N));
        chk(last_out - start == K + N, "thru_last_out", 64'(last_out - start), 64'(K + N));

        // Backpressure: 5 full cycles after the third output
        load_tab(0);
        stall_after = outs + 3;
        queue_frame();
        drain(200, "stall_timeout");

        // Saturation boundaries
        load_tab(N);
        queue_frame();
        drain(200, "sat_timeout");

        // Randomized traffic, two frames queued so next biases wait during RUN
        bias_rand = 1'b1; acc_rand = 1'b1; full_rand = 1'b1;
        for (int f = 0; f < 6; f++) begin
            rand_frame(); queue_frame();
            rand_frame(); queue_frame();
            drain(2000, "rand_timeout");
        end

        // Asynchronous reset mid-RUN with an output pending
        bias_rand = 1'b0; acc_rand = 1'b0; full_rand = 1'b0;
        rand_frame();
        queue_frame();
        guard = 0;
        while (!(m_acc >= 3 && acc_pops > outs) && guard < 100) begin
            tick();
            guard++;
        end
        chk(guard < 100, "reset_setup_timeout", 64'(guard), 64'd100);
        output_V_full_n = 1'b0;
        acc_V_empty_n   = 1'b0;
        bias_V_empty_n  = 1'b0;
        #1;
        chk(output_V_write == 1'b1, "pre_reset_write", 64'(output_V_write), 64'd1);
        #1;
        ap_rst_n = 1'b0;
        #1;
        chk(output_V_write == 1'b0, "async_reset_write", 64'(output_V_write), 64'd0);
        exp_dropped += exp_q.size();
        bias_q.delete(); acc_q.delete(); exp_q.delete();
        m_bias = 0; m_acc = 0; acc_pops = outs; prev_stall = 1'b0;
        @(negedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        output_V_full_n = 1'b1;
        @(negedge ap_clk);

        // Fresh frame after reset
        rand_frame();
        queue_frame();
        drain(200, "post_reset_timeout");
        chk(outs == exp_pushed - exp_dropped, "total_outputs", 64'(outs), 64'(exp_pushed - exp_dropped));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bias_add_stream.md
Name: bias_add_stream

Overview:
- Consumer end of the bias coefficient stream.
- LOAD phase: pops KERN_S bias coefficients from an ap_fifo-style input into a local register bank.
- RUN phase: streams PIXELS×KERN_S convolution accumulator words, channel-interleaved, adds the matching channel bias with saturation, and pushes results to an ap_fifo-style output.
- Sits between a convolution accumulator core and the next layer's input FIFO; one bias reload per frame.

Parameters:
- KERN_S, 16, number of output channels and bias words per frame
- PIXELS, 64, output pixels per frame
- COEFF_WIDTH, 16, signed bias coefficient width
- ACC_WIDTH, 32, signed accumulator input width
- OUT_WIDTH, 32, signed result width; must be ≤ ACC_WIDTH+1

Ports:
- ap_clk  in  1  clock, rising edge
- ap_rst_n  in  1  asynchronous active-low reset
- bias_V_dout  in  COEFF_WIDTH  bias word at FIFO head
- bias_V_empty_n  in  1  bias FIFO non-empty
- bias_V_read  out  1  pop bias FIFO
- acc_V_dout  in  ACC_WIDTH  accumulator word at FIFO head
- acc_V_empty_n  in  1  accumulator FIFO non-empty
- acc_V_read  out  1  pop accumulator FIFO
- output_V_din  out  OUT_WIDTH  biased result
- output_V_full_n  in  1  downstream FIFO not full
- output_V_write  out  1  push result
- frame_done  out  1  one-cycle pulse when the last input word of a frame is consumed

Behaviour:
- Reset (async assert, sync release):
  - State=LOAD; bias index, channel counter and pixel counter = 0.
  - Output register invalid, so output_V_write=0 and output_V_din=0.
  - frame_done=0. Bias bank contents are don't-care.
- FIFO semantics: head data is valid whenever empty_n=1. A read or write strobe transfers in the same cycle it is asserted.
  - bias_V_read / acc_V_read are asserted only when the matching empty_n=1.
  - A word counts as transferred on output only when output_V_write && output_V_full_n.
- LOAD:
  - bias_V_read = bias_V_empty_n.
  - Each pop stores bias_V_dout in bank[bidx]; bidx increments.
  - Pop with bidx=KERN_S-1: bidx←0, state←RUN.
  - acc_V_read=0 throughout LOAD.
- RUN:
  - acc_V_read = acc_V_empty_n && (!out_valid || output_V_full_n), so the output register is refilled in the same cycle it drains.
  - Each pop loads out_reg ← sat(sext(acc_V_dout) + sext(bank[ch])) and sets out_valid.
  - The sum is computed in ACC_WIDTH+1 bits, then saturated to signed OUT_WIDTH limits.
  - ch wraps KERN_S-1→0; pix increments on each ch wrap.
  - Pop with ch=KERN_S-1 and pix=PIXELS-1: frame_done=1 next cycle, counters←0, state←LOAD.
- Output register:
  - out_valid clears on a transfer when no refill happens that cycle.
  - output_V_din is held stable while output_V_write=1 and output_V_full_n=0.
- Latency and throughput: 1 cycle from acc pop to output_V_write. Sustained rate is one result per cycle when empty_n and full_n stay high.
- The last output of frame N may still be pending while LOAD for frame N+1 pops biases. This is legal: the bank is not read during LOAD.
- bias_V_empty_n is ignored in RUN; acc_V_empty_n is ignored in LOAD. Extra words stay in their FIFOs.
- Reset mid-frame drops the pending output, loses partial counts and returns to LOAD.

Decomposition:
- Shared package: signed saturation limits as functions of OUT_WIDTH, state encoding (LOAD, RUN), and clog2-derived counter widths for KERN_S and PIXELS.
- One natural sub-module, out_reg_stage: a single-entry ap_fifo output register with hold-under-backpressure.
- The bank, counters and FSM stay in the top.

Test Plan:
- Basic frame, KERN_S=4, PIXELS=2, biases {1,-2,3,-4}, acc 0..7 -> outputs {1,-1,5,-1,5,3,9,3}; one frame_done pulse after the 8th acc pop.
- Saturation, OUT_WIDTH=ACC_WIDTH=32, bias 100 with acc 0x7FFFFFF0 -> 0x7FFFFFFF; bias -100 with acc 0x80000010 -> 0x80000000.
- Backpressure: output_V_full_n low for 5 cycles mid-frame -> output_V_din stable, acc_V_read=0 while out_valid, no words lost or duplicated; full sequence matches golden.
- Throughput: all FIFOs always ready -> one output per cycle after the KERN_S-cycle load; RUN takes exactly PIXELS×KERN_S cycles.
- Ordering: acc words present before biases finish loading -> acc_V_read stays 0 until the KERN_S-th bias pop; bias words present during RUN -> bias_V_read stays 0.
- Reset: ap_rst_n asserted asynchronously mid-RUN (between clock edges) -> output_V_write drops immediately; after release a fresh frame loads new biases and produces correct outputs.
